id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS pipeline, placed between the IF/ID register and the EX stage.
- Decodes the incoming instruction and drives both read ports of the general-purpose register file.
- Resolves RAW hazards: forwards results from EX and MEM, and detects load-use hazards, which cause a one-cycle stall.
- Registers the ID/EX pipeline outputs, with stall and flush control and a saturating stall-cycle counter.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/id_decode.sv | 88 ++++++++
 rtl/id_stage.sv | 154 +++++++++++++++
 tb/tb_id_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: widths, opcode/funct codes, ALU operation enum.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package mips_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CNTW = 16;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;

  // SPECIAL function codes (inst[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [4:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } aluop_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational MIPS instruction decoder for the supported R/I-type subset.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inst_i directly.
// Ports: inst_i in; aluop/re1/re2/we/waddr/imm/shamt/use_shamt/is_load/illegal
//        plus the rs/rt read addresses out.
module id_decode
  import mips_pkg::*;
(
  input  logic [31:0]   inst_i,
  output aluop_t        aluop_o,
  output logic          re1_o,
  output logic          re2_o,
  output logic          we_o,
  output logic [AW-1:0] raddr1_o,
  output logic [AW-1:0] raddr2_o,
  output logic [AW-1:0] waddr_o,
  output logic [31:0]   imm_o,
  output logic [4:0]    shamt_o,
  output logic          use_shamt_o,
  output logic          is_load_o,
  output logic          illegal_o
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm16;

  assign opcode   = inst_i[31:26];
  assign funct    = inst_i[5:0];
  assign imm16    = inst_i[15:0];
  assign raddr1_o = inst_i[25:21];
  assign raddr2_o = inst_i[20:16];
  assign shamt_o  = inst_i[10:6];

  always_comb begin
    aluop_o     = ALU_NOP;
    re1_o       = 1'b0;
    re2_o       = 1'b0;
    we_o        = 1'b0;
    waddr_o     = inst_i[20:16];
    imm_o       = '0;
    use_shamt_o = 1'b0;
    is_load_o   = 1'b0;
    illegal_o   = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        waddr_o = inst_i[15:11];
        re1_o   = 1'b1;
        re2_o   = 1'b1;
        we_o    = 1'b1;
        case (funct)
          FN_ADDU: aluop_o = ALU_ADD;
          FN_SUBU: aluop_o = ALU_SUB;
          FN_AND:  aluop_o = ALU_AND;
          FN_OR:   aluop_o = ALU_OR;
          FN_XOR:  aluop_o = ALU_XOR;
          FN_NOR:  aluop_o = ALU_NOR;
          FN_SLT:  aluop_o = ALU_SLT;
          // Shifts take shamt in place of rs, so rs is not read.
          FN_SLL:  begin aluop_o = ALU_SLL; re1_o = 1'b0; use_shamt_o = 1'b1; end
          FN_SRL:  begin aluop_o = ALU_SRL; re1_o = 1'b0; use_shamt_o = 1'b1; end
          FN_SRA:  begin aluop_o = ALU_SRA; re1_o = 1'b0; use_shamt_o = 1'b1; end
          default: begin
            // Unknown funct reads nothing, so it can never cause a stall.
            re1_o     = 1'b0;
            re2_o     = 1'b0;
            we_o      = 1'b0;
            illegal_o = 1'b1;
          end
        endcase
      end
      OP_ADDIU: begin aluop_o = ALU_ADD; re1_o = 1'b1; we_o = 1'b1; imm_o = sext16(imm16); end
      OP_ANDI:  begin aluop_o = ALU_AND; re1_o = 1'b1; we_o = 1'b1; imm_o = {16'h0, imm16}; end
      OP_ORI:   begin aluop_o = ALU_OR;  re1_o = 1'b1; we_o = 1'b1; imm_o = {16'h0, imm16}; end
      OP_XORI:  begin aluop_o = ALU_XOR; re1_o = 1'b1; we_o = 1'b1; imm_o = {16'h0, imm16}; end
      OP_LUI:   begin aluop_o = ALU_LUI; we_o = 1'b1; imm_o = {imm16, 16'h0}; end
      OP_LW: begin
        aluop_o   = ALU_ADD;
        re1_o     = 1'b1;
        we_o      = 1'b1;
        is_load_o = 1'b1;
        imm_o     = sext16(imm16);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// MIPS ID stage: decode, EX/MEM operand forwarding, load-use stall, ID/EX register.
// Latency: 1 cycle i_inst -> o_*; o_ready/o_re*/o_raddr* are combinational.
// Backpressure: o_ready=0 on a load-use hazard (IF/ID must hold); flush forces o_ready=1.
// Ports: IF/ID in (i_valid,i_pc,i_inst,i_flush), regfile read ports, EX/MEM writeback
//        snoop, ID/EX outputs (o_valid..o_pc) and the saturating o_stall_cnt.
module id_stage
  import mips_pkg::*;
#(
  parameter int DW   = mips_pkg::DW,
  parameter int AW   = mips_pkg::AW,
  parameter int CNTW = mips_pkg::CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [DW-1:0]   i_pc,
  input  logic [DW-1:0]   i_inst,
  output logic            o_ready,
  input  logic            i_flush,
  output logic            o_re1,
  output logic            o_re2,
  output logic [AW-1:0]   o_raddr1,
  output logic [AW-1:0]   o_raddr2,
  input  logic [DW-1:0]   i_rdata1,
  input  logic [DW-1:0]   i_rdata2,
  input  logic            i_ex_we,
  input  logic            i_ex_is_load,
  input  logic [AW-1:0]   i_ex_waddr,
  input  logic [DW-1:0]   i_ex_wdata,
  input  logic            i_mem_we,
  input  logic [AW-1:0]   i_mem_waddr,
  input  logic [DW-1:0]   i_mem_wdata,
  output logic            o_valid,
  output aluop_t          o_aluop,
  output logic [DW-1:0]   o_op1,
  output logic [DW-1:0]   o_op2,
  output logic            o_we,
  output logic [AW-1:0]   o_waddr,
  output logic            o_is_load,
  output logic            o_illegal,
  output logic [DW-1:0]   o_pc,
  output logic [CNTW-1:0] o_stall_cnt
);

  aluop_t        dec_aluop;
  logic          dec_re1, dec_re2, dec_we, dec_use_shamt, dec_is_load, dec_illegal;
  logic [AW-1:0] rs, rt, dec_waddr;
  logic [31:0]   dec_imm;
  logic [4:0]    dec_shamt;

  id_decode u_dec (
    .inst_i      (i_inst[31:0]),
    .aluop_o     (dec_aluop),
    .re1_o       (dec_re1),
    .re2_o       (dec_re2),
    .we_o        (dec_we),
    .raddr1_o    (rs),
    .raddr2_o    (rt),
    .waddr_o     (dec_waddr),
    .imm_o       (dec_imm),
    .shamt_o     (dec_shamt),
    .use_shamt_o (dec_use_shamt),
    .is_load_o   (dec_is_load),
    .illegal_o   (dec_illegal)
  );

  assign o_re1    = dec_re1;
  assign o_re2    = dec_re2;
  assign o_raddr1 = rs;
  assign o_raddr2 = rt;

  // Operand bypass: $0 is hard zero, then the youngest producer (EX) wins over MEM.
  logic [DW-1:0] src1, src2;
  always_comb begin
    src1 = i_rdata1;
    if (rs == '0)                             src1 = '0;
    else if (i_ex_we && (i_ex_waddr == rs))   src1 = i_ex_wdata;
    else if (i_mem_we && (i_mem_waddr == rs)) src1 = i_mem_wdata;
  end
  always_comb begin
    src2 = i_rdata2;
    if (rt == '0)                             src2 = '0;
    else if (i_ex_we && (i_ex_waddr == rt))   src2 = i_ex_wdata;
    else if (i_mem_we && (i_mem_waddr == rt)) src2 = i_mem_wdata;
  end

  // A load in EX has no data yet; the consumer waits one cycle and then
  // picks the value up from the MEM bypass.
  logic hz, issue;
  assign hz = i_valid && i_ex_we && i_ex_is_load && (i_ex_waddr != '0) &&
              ((dec_re1 && (i_ex_waddr == rs)) || (dec_re2 && (i_ex_waddr == rt)));
  assign o_ready = i_flush || !hz;
  assign issue   = i_valid && !i_flush && !hz;

  logic            valid_d, valid_q, we_d, we_q, is_load_d, is_load_q, illegal_d, illegal_q;
  aluop_t          aluop_d, aluop_q;
  logic [DW-1:0]   op1_d, op1_q, op2_d, op2_q, pc_d, pc_q;
  logic [AW-1:0]   waddr_d, waddr_q;
  logic [CNTW-1:0] cnt_d, cnt_q;

  always_comb begin
    valid_d   = issue;
    we_d      = issue && dec_we;
    is_load_d = issue && dec_is_load;
    illegal_d = dec_illegal;
    aluop_d   = dec_aluop;
    waddr_d   = dec_waddr;
    pc_d      = i_pc;
    op1_d     = '0;
    if (dec_use_shamt) op1_d = DW'(dec_shamt);
    else if (dec_re1)  op1_d = src1;
    op2_d = dec_re2 ? src2 : DW'(dec_imm);
    cnt_d = cnt_q;
    if (hz && !i_flush && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      is_load_q <= 1'b0;
      illegal_q <= 1'b0;
      aluop_q   <= ALU_NOP;
      waddr_q   <= '0;
      pc_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      we_q      <= we_d;
      is_load_q <= is_load_d;
      illegal_q <= illegal_d;
      aluop_q   <= aluop_d;
      waddr_q   <= waddr_d;
      pc_q      <= pc_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_we        = we_q;
  assign o_is_load   = is_load_q;
  assign o_illegal   = illegal_q;
  assign o_aluop     = aluop_q;
  assign o_waddr     = waddr_q;
  assign o_pc        = pc_q;
  assign o_op1       = op1_q;
  assign o_op2       = op2_q;
  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed steps then randomized instructions
// checked against an instruction-semantics reference model.
// Latency/backpressure of the bench: one instruction per clock, no waits on DUT events.
module tb_id_stage;

  localparam logic [4:0] A_NOP = 5'd0, A_ADD = 5'd1, A_SUB = 5'd2, A_AND = 5'd3,
                         A_OR  = 5'd4, A_XOR = 5'd5, A_NOR = 5'd6, A_SLT = 5'd7,
                         A_SLL = 5'd8, A_SRL = 5'd9, A_SRA = 5'd10, A_LUI = 5'd11;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_flush;
  logic [31:0] i_pc, i_inst, i_rdata1, i_rdata2;
  logic        i_ex_we, i_ex_is_load, i_mem_we;
  logic [4:0]  i_ex_waddr, i_mem_waddr;
  logic [31:0] i_ex_wdata, i_mem_wdata;
  logic        o_ready, o_re1, o_re2, o_valid, o_we, o_is_load, o_illegal;
  logic [4:0]  o_raddr1, o_raddr2, o_waddr;
  mips_pkg::aluop_t o_aluop;
  logic [31:0] o_op1, o_op2, o_pc;
  logic [15:0] o_stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_pc(i_pc), .i_inst(i_inst),
    .o_ready(o_ready), .i_flush(i_flush), .o_re1(o_re1), .o_re2(o_re2),
    .o_raddr1(o_raddr1), .o_raddr2(o_raddr2), .i_rdata1(i_rdata1), .i_rdata2(i_rdata2),
    .i_ex_we(i_ex_we), .i_ex_is_load(i_ex_is_load), .i_ex_waddr(i_ex_waddr),
    .i_ex_wdata(i_ex_wdata), .i_mem_we(i_mem_we), .i_mem_waddr(i_mem_waddr),
    .i_mem_wdata(i_mem_wdata), .o_valid(o_valid), .o_aluop(o_aluop), .o_op1(o_op1),
    .o_op2(o_op2), .o_we(o_we), .o_waddr(o_waddr), .o_is_load(o_is_load),
    .o_illegal(o_illegal), .o_pc(o_pc), .o_stall_cnt(o_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference: what each instruction means, expressed as source usage plus constants.
  typedef struct {
    bit          legal;
    logic [4:0]  alu;
    bit          use_rs, use_rt, we, ld;
    logic [4:0]  wa;
    logic [31:0] k1, k2;
  } ref_t;

  function automatic ref_t ref_dec(input logic [31:0] inst);
    ref_t r;
    logic [5:0] op, fn;
    logic [15:0] im;
    op = inst[31:26]; fn = inst[5:0]; im = inst[15:0];
    r.legal = 1; r.alu = A_NOP; r.use_rs = 0; r.use_rt = 0; r.we = 1; r.ld = 0;
    r.wa = inst[20:16]; r.k1 = 0; r.k2 = 0;
    if (op == 6'h00) begin
      r.wa = inst[15:11]; r.use_rs = 1; r.use_rt = 1;
      case (fn)
        6'h21: r.alu = A_ADD;
        6'h23: r.alu = A_SUB;
        6'h24: r.alu = A_AND;
        6'h25: r.alu = A_OR;
        6'h26: r.alu = A_XOR;
        6'h27: r.alu = A_NOR;
        6'h2A: r.alu = A_SLT;
        6'h00: begin r.alu = A_SLL; r.use_rs = 0; r.k1 = 32'(inst[10:6]); end
        6'h02: begin r.alu = A_SRL; r.use_rs = 0; r.k1 = 32'(inst[10:6]); end
        6'h03: begin r.alu = A_SRA; r.use_rs = 0; r.k1 = 32'(inst[10:6]); end
        default: r.legal = 0;
      endcase
    end else begin
      case (op)
        6'h09: begin r.alu = A_ADD; r.use_rs = 1; r.k2 = 32'($signed(im)); end
        6'h0C: begin r.alu = A_AND; r.use_rs = 1; r.k2 = 32'(im); end
        6'h0D: begin r.alu = A_OR;  r.use_rs = 1; r.k2 = 32'(im); end
        6'h0E: begin r.alu = A_XOR; r.use_rs = 1; r.k2 = 32'(im); end
        6'h0F: begin r.alu = A_LUI; r.k2 = 32'(im) * 32'h10000; end
        6'h23: begin r.alu = A_ADD; r.use_rs = 1; r.ld = 1; r.k2 = 32'($signed(im)); end
        default: r.legal = 0;
      endcase
    end
    if (!r.legal) begin
      r.alu = A_NOP; r.use_rs = 0; r.use_rt = 0; r.we = 0; r.ld = 0; r.k1 = 0; r.k2 = 0;
    end
    return r;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rd);
    if (a == 0) return 0;
    if (i_ex_we && i_ex_waddr == a) return i_ex_wdata;
    if (i_mem_we && i_mem_waddr == a) return i_mem_wdata;
    return rd;
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs, rt, rd, sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Inputs already driven; checks combinational outputs, clocks once, checks ID/EX.
  task automatic cycle(input string tag);
    ref_t r;
    logic [4:0] rs, rt;
    logic hz, bub;
    logic [31:0] e1, e2;
    r = ref_dec(i_inst);
    rs = i_inst[25:21];
    rt = i_inst[20:16];
    #1;
    hz = i_valid && i_ex_we && i_ex_is_load && (i_ex_waddr != 0) &&
         ((r.use_rs && i_ex_waddr == rs) || (r.use_rt && i_ex_waddr == rt));
    chk({tag, ".ready"},  32'(o_ready),  32'(!(hz && !i_flush)));
    chk({tag, ".re1"},    32'(o_re1),    32'(r.use_rs));
    chk({tag, ".re2"},    32'(o_re2),    32'(r.use_rt));
    chk({tag, ".raddr1"}, 32'(o_raddr1), 32'(rs));
    chk({tag, ".raddr2"}, 32'(o_raddr2), 32'(rt));
    e1 = r.use_rs ? fwd(rs, i_rdata1) : r.k1;
    e2 = r.use_rt ? fwd(rt, i_rdata2) : r.k2;
    bub = !i_valid || i_flush || hz;
    if (hz && !i_flush && exp_cnt < 32'hFFFF) exp_cnt++;
    @(posedge clk);
    #2;
    chk({tag, ".valid"}, 32'(o_valid), 32'(!bub));
    chk({tag, ".we"},    32'(o_we),    32'(!bub && r.we));
    if (!bub || i_flush) chk({tag, ".is_load"}, 32'(o_is_load), 32'(!bub && r.ld));
    if (!bub) begin
      chk({tag, ".illegal"}, 32'(o_illegal), 32'(!r.legal));
      chk({tag, ".pc"}, o_pc, i_pc);
      if (r.legal) begin
        chk({tag, ".aluop"}, 32'(o_aluop), 32'(r.alu));
        chk({tag, ".op1"},   o_op1, e1);
        chk({tag, ".op2"},   o_op2, e2);
        chk({tag, ".waddr"}, 32'(o_waddr), 32'(r.wa));
      end
    end
    chk({tag, ".stall_cnt"}, 32'(o_stall_cnt), 32'(exp_cnt));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"},   32'(o_valid), 0);
    chk({tag, ".we"},      32'(o_we), 0);
    chk({tag, ".is_load"}, 32'(o_is_load), 0);
    chk({tag, ".illegal"}, 32'(o_illegal), 0);
    chk({tag, ".aluop"},   32'(o_aluop), 32'(A_NOP));
    chk({tag, ".op1"},     o_op1, 0);
    chk({tag, ".op2"},     o_op2, 0);
    chk({tag, ".waddr"},   32'(o_waddr), 0);
    chk({tag, ".pc"},      o_pc, 0);
    chk({tag, ".cnt"},     32'(o_stall_cnt), 0);
  endtask

  task automatic set_fwd(input logic ewe, eld, input logic [4:0] ewa, input logic [31:0] ewd,
                         input logic mwe, input logic [4:0] mwa, input logic [31:0] mwd);
    i_ex_we = ewe; i_ex_is_load = eld; i_ex_waddr = ewa; i_ex_wdata = ewd;
    i_mem_we = mwe; i_mem_waddr = mwa; i_mem_wdata = mwd;
  endtask

  logic [5:0] fns [10];
  logic [5:0] ops [6];

  initial begin
    fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};
    ops = '{6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23};

    // Reset with inputs that would otherwise produce non-zero outputs (LW with forwarding).
    rst = 1'b0; i_valid = 1; i_flush = 0; i_pc = 32'h400; i_rdata1 = 32'h55; i_rdata2 = 32'h66;
    i_inst = enc_i(6'h23, 5'd2, 5'd3, 16'h0010);
    set_fwd(1, 0, 5'd2, 32'h99, 1, 5'd3, 32'h88);
    repeat (2) @(posedge clk);
    #2;
    chk_reset("reset");
    rst = 1'b1;

    // ORI $1,$0,0x1234
    i_pc = 32'h1000; i_inst = enc_i(6'h0D, 5'd0, 5'd1, 16'h1234); i_rdata1 = 0;
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    cycle("ori");

    // ADDU $3,$1,$2: EX supplies $1, MEM supplies $2
    i_pc = 32'h1004; i_inst = enc_r(6'h21, 5'd1, 5'd2, 5'd3, 5'd0);
    i_rdata1 = 32'hFF; i_rdata2 = 32'hFF;
    set_fwd(1, 0, 5'd1, 32'hA, 1, 5'd2, 32'hB);
    cycle("addu_fwd");
    set_fwd(1, 0, 5'd1, 32'h5, 1, 5'd1, 32'h6);
    cycle("ex_prio");

    // Load-use: LW $4 in EX, OR $5,$4,$0 in ID
    i_pc = 32'h1008; i_inst = enc_r(6'h25, 5'd4, 5'd0, 5'd5, 5'd0); i_rdata1 = 32'h11;
    set_fwd(1, 1, 5'd4, 32'h1234, 0, 0, 0);
    cycle("lu_stall");
    set_fwd(0, 0, 0, 0, 1, 5'd4, 32'h77);
    cycle("lu_redecode");

    // Same hazard under flush
    set_fwd(1, 1, 5'd4, 32'h1234, 0, 0, 0);
    i_flush = 1;
    cycle("lu_flush");
    i_flush = 0;

    // $0 never forwarded
    i_pc = 32'h100C; i_inst = enc_r(6'h21, 5'd0, 5'd0, 5'd6, 5'd0);
    set_fwd(1, 0, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
    cycle("zero_fwd");

    // Illegal opcode
    i_inst = 32'hFC00_0000 | 32'h0021_0000;
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    cycle("illegal");

    // Bubble, shifts, LUI, LW sign extension, rd=0 destination
    i_valid = 0; cycle("bubble"); i_valid = 1;
    i_inst = enc_r(6'h03, 5'd9, 5'd3, 5'd2, 5'd5); i_rdata2 = 32'h8000_0000; cycle("sra");
    i_inst = enc_i(6'h0F, 5'd7, 5'd4, 16'h8001); cycle("lui");
    i_inst = enc_i(6'h23, 5'd1, 5'd9, 16'hFFFC); i_rdata1 = 32'h2000; cycle("lw_sext");
    i_inst = enc_i(6'h0C, 5'd1, 5'd9, 16'hFFFC); cycle("andi_zext");
    i_inst = enc_r(6'h26, 5'd1, 5'd2, 5'd0, 5'd0); cycle("rd0_we");

    // Randomized instructions, small register range to provoke collisions
    for (int n = 0; n < 300; n++) begin
      int k;
      logic [4:0] rs, rt, rd;
      k = $urandom_range(0, 16);
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      if (k < 10) i_inst = enc_r(fns[k], rs, rt, rd, 5'($urandom));
      else if (k < 16) i_inst = enc_i(ops[k-10], rs, rt, 16'($urandom));
      else i_inst = ($urandom_range(0, 1) == 0) ? enc_i(6'h3F, rs, rt, 16'($urandom))
                                                : enc_r(6'h3F, rs, rt, rd, 5'd0);
      i_pc = $urandom; i_rdata1 = $urandom; i_rdata2 = $urandom;
      i_valid = ($urandom_range(0, 9) != 0);
      i_flush = ($urandom_range(0, 9) == 0);
      set_fwd(1'($urandom), ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      cycle("rand");
    end
    i_valid = 1; i_flush = 0;

    // Drive the counter to saturation with a held hazard
    i_inst = enc_r(6'h25, 5'd4, 5'd0, 5'd5, 5'd0);
    set_fwd(1, 1, 5'd4, 0, 0, 0, 0);
    if (exp_cnt < 32'hFFFE) begin
      int gap;
      gap = 32'hFFFE - exp_cnt;
      repeat (gap) @(posedge clk);
      exp_cnt = 32'hFFFE;
      #2;
    end
    cycle("sat_reach");
    cycle("sat_hold");

    // Reset in the middle of the stall
    rst = 1'b0;
    @(posedge clk);
    #2;
    exp_cnt = 0;
    chk_reset("rst_stall");
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
